// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED breathing controller: FSM state encoding,
// default parameter values and the step-counter width.
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } led_state_e;

  localparam int LED_PWM_BITS_DEF     = 8;
  localparam int LED_STEP_PERIODS_DEF = 4;
  localparam int LED_STEP_CNT_W       = 16;

endpackage

// File: rtl/led_pwm.sv
// ---------------------------------------------------------------------------
// led_pwm
// Free-running PWM counter with a registered compare output.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   duty_eff    effective duty value compared against the counter
//   en          gates the LED drive
//   led         registered PWM output: en && (cnt < duty_eff), one cycle late
//   period_done high while the counter sits at its maximum value
// ---------------------------------------------------------------------------
module led_pwm #(
  parameter int PWM_BITS = led_pkg::LED_PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_eff,
  input  logic                en,
  output logic                led,
  output logic                period_done
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] r_cnt;
  logic                r_led;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_led <= en && (r_cnt < duty_eff);
    end
  end

  assign led         = r_led;
  assign period_done = (r_cnt == CNT_MAX);

endmodule

// File: rtl/led_breathe.sv
// ---------------------------------------------------------------------------
// led_breathe
// LED "breathing" controller: ramps a PWM duty value up and down linearly,
// one step every STEP_PERIODS complete PWM periods.
// Optional feature macro: LED_BREATHE_GAMMA_EN -- when defined, the PWM
// compares against the upper half of duty*duty for a perceptual curve; the
// duty port always carries the linear ramp value.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          breathing enable, level-sensitive
//   led         registered PWM drive
//   duty        current linear ramp duty
//   period_done one-cycle pulse on the last cycle of each PWM period
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | disabled, duty and step counter held at 0
// ST_UP   | duty rising one step per step event
// ST_DOWN | duty falling one step per step event
// ---------------------------------------------------------------------------
module led_breathe
  import led_pkg::*;
#(
  parameter int PWM_BITS     = LED_PWM_BITS_DEF,
  parameter int STEP_PERIODS = LED_STEP_PERIODS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic                period_done
);

  localparam logic [PWM_BITS-1:0]       DUTY_MAX  = '1;
  localparam logic [LED_STEP_CNT_W-1:0] STEP_LAST = LED_STEP_CNT_W'(STEP_PERIODS - 1);

  led_state_e                r_state, w_state_nxt;
  logic [PWM_BITS-1:0]       r_duty, w_duty_nxt;
  logic [LED_STEP_CNT_W-1:0] r_step_cnt, w_step_nxt;
  logic [PWM_BITS-1:0]       w_duty_eff;
  logic                      w_period_done;
  logic                      w_step;

  // Step event fires on the STEP_PERIODS-th period_done pulse.
  assign w_step = w_period_done && (r_step_cnt == STEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // en dropping outranks a coincident step event.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_UP;
      ST_UP: begin
        if (!en)                               w_state_nxt = ST_IDLE;
        else if (w_step && r_duty == DUTY_MAX) w_state_nxt = ST_DOWN;
      end
      ST_DOWN: begin
        if (!en)                          w_state_nxt = ST_IDLE;
        else if (w_step && r_duty == '0)  w_state_nxt = ST_UP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Turnaround values (max-1 / 1) keep each endpoint to a single step.
  always_comb begin
    w_duty_nxt = r_duty;
    w_step_nxt = r_step_cnt;
    case (r_state)
      ST_UP, ST_DOWN: begin
        if (!en) begin
          w_duty_nxt = '0;
          w_step_nxt = '0;
        end else if (w_step) begin
          w_step_nxt = '0;
          if (r_state == ST_UP)
            w_duty_nxt = (r_duty == DUTY_MAX) ? DUTY_MAX - 1'b1 : r_duty + 1'b1;
          else
            w_duty_nxt = (r_duty == '0) ? PWM_BITS'(1) : r_duty - 1'b1;
        end else if (w_period_done) begin
          w_step_nxt = r_step_cnt + 1'b1;
        end
      end
      default: begin
        w_duty_nxt = '0;
        w_step_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty     <= '0;
      r_step_cnt <= '0;
    end else begin
      r_duty     <= w_duty_nxt;
      r_step_cnt <= w_step_nxt;
    end
  end

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_duty_sq;
  assign w_duty_sq  = r_duty * r_duty;
  assign w_duty_eff = w_duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign w_duty_eff = r_duty;
`endif

  led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk         (clk),
    .rst         (rst),
    .duty_eff    (w_duty_eff),
    .en          (en),
    .led         (led),
    .period_done (w_period_done)
  );

  assign duty        = r_duty;
  assign period_done = w_period_done;

endmodule

// File: tb/tb_led_breathe.sv
module tb_led_breathe;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_m, en_s;
  logic       led_m, led_s, pd_m, pd_s;
  logic [3:0] duty_m, duty_s;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int highs  = 0;

  always #5 clk = ~clk;

  led_breathe #(.PWM_BITS(4), .STEP_PERIODS(1)) u_dut (
    .clk(clk), .rst(rst), .en(en_m), .led(led_m), .duty(duty_m), .period_done(pd_m)
  );

  led_breathe #(.PWM_BITS(4), .STEP_PERIODS(64)) u_dut_slow (
    .clk(clk), .rst(rst), .en(en_s), .led(led_s), .duty(duty_s), .period_done(pd_s)
  );

  typedef struct {
    int n;
    int exp_duty;
    int exp_pd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%0d required=%0d", name, n, act, exp);
    end
  endtask

  function automatic int eff(input int d);
`ifdef LED_BREATHE_GAMMA_EN
    return (d * d) >> 4;
`else
    return d;
`endif
  endfunction

  // Expected linear duty, STEP_PERIODS=1, en held high from reset release.
  function automatic int tri_duty(input int c);
    int k;
    k = (c / 16) % 30;
    return (k <= 15) ? k : 30 - k;
  endfunction

  initial begin
    tbl[0]  = '{15, 0, 1};
    tbl[1]  = '{16, 1, 0};
    tbl[2]  = '{31, 1, 1};
    tbl[3]  = '{240, 15, 0};
    tbl[4]  = '{255, 15, 1};
    tbl[5]  = '{256, 14, 0};
    tbl[6]  = '{464, 1, 0};
    tbl[7]  = '{479, 1, 1};
    tbl[8]  = '{480, 0, 0};
    tbl[9]  = '{495, 0, 1};
    tbl[10] = '{496, 1, 0};
    tbl[11] = '{512, 2, 0};

    // Reset hold, then idle with en low.
    rst = 1'b1; en_m = 1'b0; en_s = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_led", led_m, 0);
    chk("rst_duty", duty_m, 0);
    chk("rst_pd", pd_m, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      n = i;
      chk("idle_led", led_m, 0);
      chk("idle_duty", duty_m, 0);
      chk("idle_pd", pd_m, ((n % 16) == 15) ? 1 : 0);
      chk("idle_duty_slow", duty_s, 0);
    end

    // Breathing run from a fresh reset with en high.
    rst = 1'b1; en_m = 1'b1; en_s = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    chk("start_duty", duty_m, 0);
    for (int i = 1; i <= 9300; i++) begin
      @(posedge clk); #1;
      n = i;
      if (n <= 630) begin
        chk("ramp_duty", duty_m, tri_duty(n));
        chk("ramp_led", led_m, (((n - 1) % 16) < eff(tri_duty(n - 1))) ? 1 : 0);
        chk("ramp_pd", pd_m, ((n % 16) == 15) ? 1 : 0);
      end
      for (int j = 0; j < 12; j++) begin
        if (tbl[j].n == n) begin
          chk("tbl_duty", duty_m, tbl[j].exp_duty);
          chk("tbl_pd", pd_m, tbl[j].exp_pd);
        end
      end
      if (n >= 631 && n <= 651) begin
        chk("drop_duty", duty_m, 0);
        chk("drop_led", led_m, 0);
      end
      if (n == 653) chk("restart_duty0", duty_m, 0);
      if (n == 656) chk("restart_duty1", duty_m, 1);
      if (n == 672) chk("restart_duty2", duty_m, 2);
      if (n == 630) begin
        chk("pre_drop_duty", duty_m, 9);
        en_m = 1'b0;
      end
      if (n == 651) en_m = 1'b1;

      if (n == 5200) chk("freeze_duty", duty_s, 5);
      if (n >= 5200 && n < 5264)
        chk("freeze_led", led_s, (((n - 1) % 16) < eff(5)) ? 1 : 0);
      if (n == 8200) chk("duty8", duty_s, 8);
      if (n >= 8201 && n <= 8216 && led_s) highs++;
      if (n == 8216) chk("duty8_high_cnt", highs, eff(8));
    end

    // Asynchronous reset between clock edges mid-ramp.
    chk("pre_rst_duty_slow", duty_s, 9);
    #3;
    rst = 1'b1;
    #1;
    chk("async_led", led_m, 0);
    chk("async_duty", duty_m, 0);
    chk("async_pd", pd_m, 0);
    chk("async_led_slow", led_s, 0);
    chk("async_duty_slow", duty_s, 0);
    chk("async_pd_slow", pd_s, 0);
    repeat (2) @(posedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
